shifter_pipe: RTL



---
 rtl/shifter_pkg.sv | 13 +
 rtl/shifter_stage.sv | 69 ++++++
 rtl/shifter_pipe.sv | 57 +++++
 3 files changed

// File: rtl/shifter_pkg.sv
// shifter_pkg: op encoding shared by the pipelined barrel shifter
//    op_t   3-bit operation code
//    OP_*   operation constants; 110/111 are pass-through
package shifter_pkg;
   typedef logic [2:0] op_t;
   localparam op_t OP_SRL  = 3'b000;
   localparam op_t OP_SRA  = 3'b001;
   localparam op_t OP_SLL  = 3'b010;
   localparam op_t OP_SLL2 = 3'b011;
   localparam op_t OP_ROR  = 3'b100;
   localparam op_t OP_ROL  = 3'b101;
   localparam op_t OP_PASS = 3'b110;
endpackage

// File: rtl/shifter_stage.sv
// shifter_stage: one registered conditional shift by 2^K with carry and handshake
//    in_valid/in_d/in_op/in_b/in_carry  op entering this stage
//    nxt_ld   downstream stage (or consumer) takes this stage's op
//    ld       this stage loads this cycle
//    out_*    registered op for the next stage
//    SHIFTER_ROTATE_EN  enables ROR/ROL muxing; otherwise those ops pass through
module shifter_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int K = 0,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_d,
   input  op_t              in_op,
   input  logic [SHW-1:0]   in_b,
   input  logic             in_carry,
   input  logic             nxt_ld,
   output logic             ld,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_d,
   output op_t              out_op,
   output logic [SHW-1:0]   out_b,
   output logic             out_carry
);
   localparam int S = 1 << K;
   logic sh, nc;
   logic [WIDTH-1:0] nd, sra;
   assign ld  = !out_valid || nxt_ld;
   assign sra = $signed(in_d) >>> S;
   always_comb begin
`ifdef SHIFTER_ROTATE_EN
      sh = in_b[K] && !(in_op[2] && in_op[1]);
      nd = !sh ? in_d :
           in_op == OP_SRL ? in_d >> S :
           in_op == OP_SRA ? sra :
           in_op == OP_ROR ? {in_d[S-1:0], in_d[WIDTH-1:S]} :
           in_op == OP_ROL ? {in_d[WIDTH-S-1:0], in_d[WIDTH-1:WIDTH-S]} :
           in_d << S;
`else
      sh = in_b[K] && !in_op[2];
      nd = !sh ? in_d :
           in_op == OP_SRL ? in_d >> S :
           in_op == OP_SRA ? sra :
           in_d << S;
`endif
      // new MSB after ROR and new LSB after ROL are the same bits SRL/SLL shift out
      nc = !sh ? in_carry :
           (in_op == OP_SRL || in_op == OP_SRA || in_op == OP_ROR) ? in_d[S-1] : in_d[WIDTH-S];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_d     <= '0;
         out_op    <= OP_SRL;
         out_b     <= '0;
         out_carry <= 1'b0;
      end else if (ld) begin
         out_valid <= in_valid;
         out_d     <= nd;
         out_op    <= in_op;
         out_b     <= in_b;
         out_carry <= nc;
      end
   end
endmodule

// File: rtl/shifter_pipe.sv
// shifter_pipe: fully pipelined barrel shifter with rotate, carry-out and valid/ready
//    in_valid/in_ready   input handshake; in_a operand, in_b amount, in_op operation
//    out_valid/out_ready output handshake; out_c result, out_carry last bit shifted out
//    SHIFTER_ROTATE_EN   enables ROR/ROL; otherwise ops 100/101 pass through
module shifter_pipe
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [$clog2(WIDTH)-1:0] in_b,
   input  op_t                      in_op,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_c,
   output logic                     out_carry
);
   localparam int SHW = $clog2(WIDTH);
   logic [SHW:0] v, ld, c;
   logic [WIDTH-1:0] d [SHW+1];
   op_t op [SHW+1];
   logic [SHW-1:0] b [SHW+1];
   logic unused_tail;
   assign v[0]      = in_valid;
   assign d[0]      = in_a;
   assign op[0]     = in_op;
   assign b[0]      = in_b;
   assign c[0]      = 1'b0;
   assign ld[SHW]   = out_ready;
   assign in_ready  = ld[0];
   assign out_valid = v[SHW];
   assign out_c     = d[SHW];
   assign out_carry = c[SHW];
   assign unused_tail = ^{op[SHW], b[SHW]};
   for (genvar k = 0; k < SHW; k++) begin : g_stage
      shifter_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (v[k]),
         .in_d      (d[k]),
         .in_op     (op[k]),
         .in_b      (b[k]),
         .in_carry  (c[k]),
         .nxt_ld    (ld[k+1]),
         .ld        (ld[k]),
         .out_valid (v[k+1]),
         .out_d     (d[k+1]),
         .out_op    (op[k+1]),
         .out_b     (b[k+1]),
         .out_carry (c[k+1])
      );
   end
endmodule
